// File: rtl/dm_store_buffer.sv
// dm_store_buffer: MEM-stage store buffer.
// Checks store alignment, formats sb/sh/sw into word address + byte enables
// + lane-replicated data, queues them in a small FIFO drained over
// valid/ready, and flags loads whose word matches a pending store.
module dm_store_buffer #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [1:0]       st_type,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    output logic             st_exc,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_byteen,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // Entry storage: word address bits [31:2], byte enables, write data.
    logic [29:0] addr_reg   [DEPTH];
    logic [3:0]  byteen_reg [DEPTH];
    logic [31:0] wdata_reg  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;

    logic        misaligned;
    logic [3:0]  fmt_byteen;
    logic [31:0] fmt_wdata;
    logic        enq;
    logic        deq;
    logic [DEPTH-1:0] entry_hit;

    // Alignment check and lane formatting of the incoming store.
    always_comb begin
        misaligned = 1'b0;
        fmt_byteen = 4'b0000;
        fmt_wdata  = 32'h0;
        case (st_type)
            2'b01: begin
                fmt_byteen = 4'b0001 << st_addr[1:0];
                fmt_wdata  = {4{st_data[7:0]}};
            end
            2'b10: begin
                misaligned = st_addr[0];
                fmt_byteen = st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata  = {2{st_data[15:0]}};
            end
            2'b11: begin
                misaligned = (st_addr[1:0] != 2'b00);
                fmt_byteen = 4'b1111;
                fmt_wdata  = st_data;
            end
            default: ;
        endcase
    end

    assign st_ready  = (count_reg != FULL_COUNT);
    assign st_exc    = st_valid & misaligned;
    assign enq       = st_valid & (st_type != 2'b00) & ~misaligned & st_ready;
    assign mem_valid = (count_reg != '0);
    assign deq       = mem_valid & mem_ready;
    assign count     = count_reg;

    // Head entry drives memory; zeros when the buffer is empty.
    assign mem_addr   = mem_valid ? {addr_reg[rd_ptr_reg], 2'b00} : 32'h0;
    assign mem_byteen = mem_valid ? byteen_reg[rd_ptr_reg] : 4'b0000;
    assign mem_wdata  = mem_valid ? wdata_reg[rd_ptr_reg] : 32'h0;

    // Next pointer/occupancy values from the enqueue/dequeue pair.
    always_comb begin
        rd_ptr_next = deq ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
        wr_ptr_next = enq ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
        count_next  = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers; reset discards all pending entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry payload write; contents are only meaningful while occupied.
    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            addr_reg[wr_ptr_reg]   <= st_addr[31:2];
            byteen_reg[wr_ptr_reg] <= fmt_byteen;
            wdata_reg[wr_ptr_reg]  <= fmt_wdata;
        end
    end

    // Per-entry load hazard: entry occupied and same word address.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PTR_W-1:0] slot_off;
            assign slot_off      = PTR_W'(gi) - rd_ptr_reg;
            assign entry_hit[gi] = ({1'b0, slot_off} < count_reg) &&
                                   (addr_reg[gi] == ld_addr[31:2]);
        end
    endgenerate

    assign ld_hit = ld_valid & (|entry_hit);

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Store-side counterpart of the load read extender in the MEM stage.
- Takes store requests (sb/sh/sw) from the pipeline and checks alignment.
- Converts each store into a word-aligned address, a 4-bit byte enable and lane-replicated write data.
- Queues stores in a small FIFO that drains to data memory over a valid/ready handshake; reports load-address hazards against pending stores so the pipeline can stall loads.

Parameters:
- DEPTH, 2, number of store-buffer entries; must be a power of 2 and at least 2.
- PTR_W, 1, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  store request present this cycle.
- st_type  input  2  00 none, 01 byte, 10 half, 11 word.
- st_addr  input  32  byte address of the store.
- st_data  input  32  rt register value; the low byte or half is used for narrow stores.
- st_ready  output  1  buffer can accept a store.
- st_exc  output  1  misaligned-store exception.
- ld_valid  input  1  load in the MEM stage.
- ld_addr  input  32  load byte address.
- ld_hit  output  1  load word matches a pending store.
- mem_valid  output  1  head entry presented to data memory.
- mem_addr  output  32  word address {addr[31:2],2'b00}.
- mem_byteen  output  4  byte enables; bit i covers data[8i+7:8i].
- mem_wdata  output  32  lane-replicated write data.
- mem_ready  input  1  data memory accepts the head entry.
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Reset (synchronous): count=0, rd_ptr=wr_ptr=0, mem_valid=0, mem_byteen=0, mem_wdata=0, mem_addr=0. Pending entries are discarded, including one mid-handshake.
- st_ready = (count != DEPTH). Purely registered state; no same-cycle dequeue bypass.
- Misaligned cases:
  - half with st_addr[0]=1 is misaligned.
  - word with st_addr[1:0]!=0 is misaligned.
  - byte is never misaligned.
- st_exc = st_valid & misaligned. It is combinational, independent of st_ready, and a misaligned store is never enqueued.
- Enqueue condition: st_valid & st_type!=00 & !misaligned & st_ready. st_type=00 is ignored.
- Entry formatting at enqueue:
  - byte: byteen = 4'b0001 << st_addr[1:0]; wdata = {4{st_data[7:0]}}.
  - half: byteen = st_addr[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - word: byteen = 4'b1111; wdata = st_data.
  - Stored address = {st_addr[31:2],2'b00}.
- Output: mem_valid = (count != 0). mem_addr/mem_byteen/mem_wdata come from the entry at rd_ptr; when empty, all three drive 0.
- Output fields stay stable while mem_valid & !mem_ready.
- Dequeue on mem_valid & mem_ready, which advances rd_ptr.
- Latency: a store enqueued at edge N appears on mem_* from cycle N+1 when the buffer was empty. FIFO order is strict.
- Simultaneous enqueue and dequeue (0 < count < DEPTH): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- ld_hit = ld_valid & (some occupied entry has stored address [31:2] == ld_addr[31:2]). Byte enables are not considered.
- ld_hit is combinational. A store enqueued in the same cycle does not count until the next cycle.
- Full with mem_ready=0: st_ready=0. A request presented in that cycle is not taken, and the pipeline must hold it.
- Full with mem_ready=1: dequeue only. st_ready rises the next cycle.

Test Plan:
1. After reset, sb addr 0x00000013, data 0x000000AB -> next cycle: mem_valid=1, mem_addr=0x00000010, mem_byteen=1000, mem_wdata=0xABABABAB. With mem_ready=1, count returns to 0.
2. sh addr 0x00000022, data 0x1234BEEF -> mem_addr=0x00000020, mem_byteen=1100, mem_wdata=0xBEEFBEEF. sw addr 0x40, data 0xDEADBEEF -> byteen=1111, wdata=0xDEADBEEF.
3. sh addr 0x00000011 and sw addr 0x00000042 -> st_exc=1 in that cycle, count unchanged, no mem_valid.
4. Hold mem_ready=0 and issue 3 stores (DEPTH=2) -> count=2, st_ready=0 after the second, third not accepted. Outputs stay on the first entry. Release mem_ready -> entries drain in order, one per cycle.
5. Pending sw to 0x80 with load ld_addr=0x83 -> ld_hit=1. ld_addr=0x84 -> ld_hit=0. After drain -> ld_hit=0.
6. Two entries pending, mem_valid=1; assert reset one cycle -> next cycle count=0, mem_valid=0, st_ready=1. Repeat with enqueue and dequeue in the same cycle at count=1 -> count stays 1, pointers wrap correctly.
